rs3_operand_sched: RTL and testbench
====================================

// Module: rs3_operand_sched
// PURPOSE
// - Sequences operand fetch for issued instructions through a 2-read-port register file.
// - Three-source muladd instructions take one extra read cycle, in which the rs3 mux select is driven to MULADD.
// - Sits between decode and the execute stage; owns rf port addresses and the rs3_sel control.
// - Delivers a latched operand triple to execute over a valid/ready handshake.
// PARAMETERS
// - ADDR_WIDTH  `ADDR_WIDTH  register address width
// - DATA_WIDTH  32           register data width
// - MULADD      2'b10        rs3_sel encoding that routes the muladd rs3 address
// - CNT_WIDTH   16           width of the muladd issue counter
// PORTS
// - clk          in   1           clock, rising edge
// - rst_n        in   1           asynchronous active-low reset
// - flush        in   1           synchronous abort of the instruction in flight
// - instr_valid  in   1           decode presents an instruction
// - instr_ready  out  1           scheduler can accept
// - is_muladd    in   1           instruction needs rs3
// - rs1, rs2, rs3  in  ADDR_WIDTH  source register addresses
// - rf_addr0, rf_addr1  out  ADDR_WIDTH  rf read port addresses
// - rf_data0, rf_data1  in   DATA_WIDTH  rf read data, combinational from the address in the same cycle
// - rs3_sel      out  2           MULADD during the rs3 read cycle, else 2'b00
// - op_a, op_b, op_c  out  DATA_WIDTH  latched operands
// - op_valid     out  1           operands available
// - op_ready     in   1           execute accepts
// - muladd_cnt   out  CNT_WIDTH   count of completed muladd handoffs
// BEHAVIOUR
// - Reset: state IDLE; every output 0 except instr_ready=1; latched addresses cleared.
// - FSM states:
//   - IDLE:  instr_ready=1. On instr_valid, latch rs1/rs2/rs3/is_muladd and go to RD_AB.
//   - RD_AB: rf_addr0=rs1, rf_addr1=rs2. At the clock edge capture op_a<=rf_data0 and op_b<=rf_data1.
//            Next state: RD_C if muladd, else OUT with op_c<=0.
//   - RD_C:  rf_addr0=rs3, rf_addr1=0, rs3_sel=MULADD. Capture op_c<=rf_data0; go to OUT.
//   - OUT:   op_valid=1. On op_ready, go to IDLE and increment muladd_cnt if the instruction was muladd.
// - rf_addr0, rf_addr1 and rs3_sel are 0 in IDLE and OUT.
// - Latency, accept edge to op_valid high: 2 cycles for non-muladd, 3 for muladd. No back-to-back overlap.
// - instr_ready=0 in every state except IDLE; instr_valid outside IDLE is ignored.
// - op_valid = (state==OUT) & ~flush.
//   - op_a, op_b and op_c hold stable while op_valid=1 and op_ready=0.
// - flush, in any non-IDLE state: next state is IDLE, muladd_cnt does not increment, op_* keep their stale values.
//   - flush together with op_ready in OUT: flush wins; no transfer occurs.
//   - flush in IDLE has priority over accept: the instruction is not latched.
// - muladd_cnt wraps modulo 2^CNT_WIDTH.
// - rst_n asserted mid-operation: immediate return to reset values; the in-flight instruction is lost.
// CONFIGURATION
// - RS3_ZERO_SKIP_EN defined:
//   - A muladd with rs3==0 goes RD_AB->OUT with op_c<=0 and never enters RD_C.
//   - Latency drops to 2 cycles; rs3_sel is never driven for it; muladd_cnt still counts it.
// - RS3_ZERO_SKIP_EN undefined: every muladd takes RD_C, including rs3==0.
// TESTING
// - Non-muladd, rs1=3 rs2=5, rf[3]=0x11 rf[5]=0x22, op_ready=1
//   -> op_valid 2 cycles after accept; op_a=0x11 op_b=0x22 op_c=0; rs3_sel stays 0.
// - Muladd, rs3=7, rf[7]=0xABCD
//   -> exactly one cycle with rs3_sel=2'b10 and rf_addr0=7; op_c=0xABCD; op_valid at 3 cycles; muladd_cnt +1.
// - op_ready held low 5 cycles in OUT
//   -> op_valid stays 1, operands stable, instr_ready=0; a new instr_valid in that window is not accepted.
// - flush during RD_C
//   -> IDLE next cycle, op_valid never rises, muladd_cnt unchanged; next instruction accepted normally.
// - muladd_cnt preloaded to 0xFFFF by 65535 muladds, one more muladd -> muladd_cnt=0x0000.
// - Muladd with rs3=0: with RS3_ZERO_SKIP_EN -> 2-cycle latency, rs3_sel never 2'b10;
//   without it -> 3-cycle latency, op_c=rf[0].

Source files
------------

// File: rtl/rs3_operand_sched_if.sv
// Decode/rf/execute bundle around the rs3 operand scheduler.
// master = surrounding pipeline, slave = scheduler.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif

interface rs3_operand_sched_if #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  flush;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  is_muladd;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] rs3;
    logic [ADDR_WIDTH-1:0] rf_addr0;
    logic [ADDR_WIDTH-1:0] rf_addr1;
    logic [DATA_WIDTH-1:0] rf_data0;
    logic [DATA_WIDTH-1:0] rf_data1;
    logic [1:0]            rs3_sel;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] op_c;
    logic                  op_valid;
    logic                  op_ready;
    logic [CNT_WIDTH-1:0]  muladd_cnt;

    modport master (
        output flush, instr_valid, is_muladd, rs1, rs2, rs3, rf_data0, rf_data1, op_ready,
        input  instr_ready, rf_addr0, rf_addr1, rs3_sel, op_a, op_b, op_c, op_valid, muladd_cnt
    );

    modport slave (
        input  flush, instr_valid, is_muladd, rs1, rs2, rs3, rf_data0, rf_data1, op_ready,
        output instr_ready, rf_addr0, rf_addr1, rs3_sel, op_a, op_b, op_c, op_valid, muladd_cnt
    );
endinterface

// File: rtl/rs3_operand_sched.sv
// Operand fetch sequencer over a 2-read-port rf; muladd spends one extra cycle reading rs3 (RS3_ZERO_SKIP_EN skips it for rs3==0).
// Accept-to-op_valid is 2 cycles (3 with the rs3 read); holds operands and instr_ready=0 until execute takes them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif

module rs3_operand_sched #(
    parameter int         ADDR_WIDTH = `ADDR_WIDTH,
    parameter int         DATA_WIDTH = 32,
    parameter logic [1:0] MULADD     = 2'b10,
    parameter int         CNT_WIDTH  = 16
) (
    input logic               clk,
    input logic               rst_n,
    rs3_operand_sched_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RD_AB, RD_C, OUT} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] rs3_q;
    logic                  muladd_q;
    logic                  rdy_q;
    logic [ADDR_WIDTH-1:0] addr0_q;
    logic [ADDR_WIDTH-1:0] addr1_q;
    logic [1:0]            sel_q;
    logic [DATA_WIDTH-1:0] op_a_q;
    logic [DATA_WIDTH-1:0] op_b_q;
    logic [DATA_WIDTH-1:0] op_c_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  skip_c;

`ifdef RS3_ZERO_SKIP_EN
    assign skip_c = ~muladd_q | (rs3_q == '0);
`else
    assign skip_c = ~muladd_q;
`endif

    // Outputs default to their idle values each cycle; each state overrides what it keeps alive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rs3_q    <= '0;
            muladd_q <= 1'b0;
            rdy_q    <= 1'b1;
            addr0_q  <= '0;
            addr1_q  <= '0;
            sel_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_c_q   <= '0;
            cnt_q    <= '0;
        end else begin
            rdy_q   <= 1'b1;
            addr0_q <= '0;
            addr1_q <= '0;
            sel_q   <= '0;
            case (state)
                IDLE: begin
                    if (bus.instr_valid && !bus.flush) begin
                        state    <= RD_AB;
                        rdy_q    <= 1'b0;
                        addr0_q  <= bus.rs1;
                        addr1_q  <= bus.rs2;
                        rs3_q    <= bus.rs3;
                        muladd_q <= bus.is_muladd;
                    end
                end
                RD_AB: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        rdy_q  <= 1'b0;
                        op_a_q <= bus.rf_data0;
                        op_b_q <= bus.rf_data1;
                        if (skip_c) begin
                            op_c_q <= '0;
                            state  <= OUT;
                        end else begin
                            state   <= RD_C;
                            addr0_q <= rs3_q;
                            sel_q   <= MULADD;
                        end
                    end
                end
                RD_C: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        rdy_q  <= 1'b0;
                        op_c_q <= bus.rf_data0;
                        state  <= OUT;
                    end
                end
                OUT: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else if (bus.op_ready) begin
                        state <= IDLE;
                        if (muladd_q) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        rdy_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.instr_ready = rdy_q;
    assign bus.rf_addr0    = addr0_q;
    assign bus.rf_addr1    = addr1_q;
    assign bus.rs3_sel     = sel_q;
    assign bus.op_a        = op_a_q;
    assign bus.op_b        = op_b_q;
    assign bus.op_c        = op_c_q;
    assign bus.op_valid    = (state == OUT) && !bus.flush;
    assign bus.muladd_cnt  = cnt_q;

endmodule

// File: tb/tb_rs3_operand_sched.sv
// Scoreboard bench for rs3_operand_sched: expected operands queued at accept, compared at handoff.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif

module tb_rs3_operand_sched;
    localparam int AW = `ADDR_WIDTH;
    localparam int CW = 8;

    typedef struct packed {
        logic        m;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } ops_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rs3_operand_sched_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .CNT_WIDTH(CW)) bus();

    rs3_operand_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .MULADD(2'b10), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [31:0] rf [2**AW];
    assign bus.rf_data0 = rf[bus.rf_addr0];
    assign bus.rf_data1 = rf[bus.rf_addr1];

    int          checks = 0;
    int          errors = 0;
    ops_t        exp_q[$];
    ops_t        exp_ops;
    ops_t        got;
    logic [CW-1:0] mdl_cnt = '0;
    logic        accepted = 1'b0;
    logic        handoff = 1'b0;
    logic        pending = 1'b0;
    int          n_acc = 0;
    int          since_acc = 0;
    int          lat = -1;
    int          sel_cycles = 0;
    logic [AW-1:0] sel_addr = '0;

    function automatic logic [31:0] exp_c(input logic m, input logic [AW-1:0] r3);
`ifdef RS3_ZERO_SKIP_EN
        if (m && r3 == '0) return 32'h0;
`endif
        return m ? rf[r3] : 32'h0;
    endfunction

    function automatic int exp_lat(input logic m, input logic [AW-1:0] r3);
`ifdef RS3_ZERO_SKIP_EN
        if (m && r3 == '0) return 2;
`endif
        return m ? 3 : 2;
    endfunction

    // One cycle: observe at negedge, then move to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        handoff = 1'b0;
        if (rst_n && bus.instr_valid && bus.instr_ready && !bus.flush) begin
            accepted   = 1'b1;
            n_acc++;
            since_acc  = 0;
            lat        = -1;
            sel_cycles = 0;
            sel_addr   = '0;
            pending    = 1'b1;
            exp_q.push_back('{m: bus.is_muladd, a: rf[bus.rs1], b: rf[bus.rs2],
                              c: exp_c(bus.is_muladd, bus.rs3)});
        end else begin
            accepted = 1'b0;
            since_acc++;
        end
        if (bus.rs3_sel == 2'b10) begin
            sel_cycles++;
            sel_addr = bus.rf_addr0;
        end
        if (bus.op_valid && lat < 0) lat = since_acc;
        if (bus.op_valid && bus.op_ready) begin
            handoff = 1'b1;
            pending = 1'b0;
            got = '{m: 1'b0, a: bus.op_a, b: bus.op_b, c: bus.op_c};
            if (exp_q.size() > 0) exp_ops = exp_q.pop_front();
            else exp_ops = '1;
            if (exp_ops.m) mdl_cnt = mdl_cnt + 1'b1;
        end else if (bus.flush && pending) begin
            pending = 1'b0;
            void'(exp_q.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic m, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic [AW-1:0] r3, output bit ok);
        bus.is_muladd   = m;
        bus.rs1         = r1;
        bus.rs2         = r2;
        bus.rs3         = r3;
        bus.instr_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (accepted) begin
                ok = 1'b1;
                break;
            end
        end
        bus.instr_valid = 1'b0;
    endtask

    task automatic run_out(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (handoff) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_instr_ready got %0h exp 1", bus.instr_ready); end
        checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid got %0h exp 0", bus.op_valid); end
        checks++; if ({bus.rf_addr0, bus.rf_addr1, bus.rs3_sel} !== '0) begin errors++; $display("FAIL reset_rf_ctl got %0h/%0h/%0h exp 0", bus.rf_addr0, bus.rf_addr1, bus.rs3_sel); end
        checks++; if ({bus.op_a, bus.op_b, bus.op_c, bus.muladd_cnt} !== '0) begin errors++; $display("FAIL reset_ops got %0h %0h %0h cnt %0h exp 0", bus.op_a, bus.op_b, bus.op_c, bus.muladd_cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_plain();
        bit ok;
        bus.op_ready = 1'b1;
        send(1'b0, 5'd3, 5'd5, 5'd9, ok);
        checks++; if (!ok) begin errors++; $display("FAIL plain_accept got none exp accept"); end
        run_out(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL plain_handoff got timeout exp handoff"); end
        checks++; if (lat != 2) begin errors++; $display("FAIL plain_latency got %0d exp 2", lat); end
        checks++; if (sel_cycles != 0) begin errors++; $display("FAIL plain_rs3_sel got %0d cycles exp 0", sel_cycles); end
        checks++; if ({got.a, got.b, got.c} !== {32'h11, 32'h22, 32'h0}) begin errors++; $display("FAIL plain_ops got %0h %0h %0h exp 11 22 0", got.a, got.b, got.c); end
        checks++; if (bus.muladd_cnt !== mdl_cnt) begin errors++; $display("FAIL plain_cnt got %0h exp %0h", bus.muladd_cnt, mdl_cnt); end
    endtask

    task automatic test_muladd();
        bit ok;
        bus.op_ready = 1'b1;
        send(1'b1, 5'd3, 5'd5, 5'd7, ok);
        run_out(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL muladd_handoff got timeout exp handoff"); end
        checks++; if (lat != 3) begin errors++; $display("FAIL muladd_latency got %0d exp 3", lat); end
        checks++; if (sel_cycles != 1 || sel_addr != 5'd7) begin errors++; $display("FAIL muladd_rs3_sel got %0d cycles addr %0d exp 1 cycle addr 7", sel_cycles, sel_addr); end
        checks++; if ({got.a, got.b, got.c} !== {exp_ops.a, exp_ops.b, exp_ops.c} || got.c !== 32'hABCD) begin errors++; $display("FAIL muladd_ops got %0h %0h %0h exp %0h %0h %0h", got.a, got.b, got.c, exp_ops.a, exp_ops.b, exp_ops.c); end
        checks++; if (bus.muladd_cnt !== mdl_cnt) begin errors++; $display("FAIL muladd_cnt got %0h exp %0h", bus.muladd_cnt, mdl_cnt); end
    endtask

    task automatic test_stall();
        bit ok;
        logic [95:0] hold;
        int acc0;
        bus.op_ready = 1'b0;
        send(1'b1, 5'd4, 5'd6, 5'd8, ok);
        for (int i = 0; i < 10 && lat < 0; i++) tick();
        hold = {bus.op_a, bus.op_b, bus.op_c};
        acc0 = n_acc;
        bus.rs1 = 5'd9;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.op_valid !== 1'b1 || bus.instr_ready !== 1'b0) begin errors++; $display("FAIL stall_hs cycle %0d got valid %0h ready %0h exp 1 0", i, bus.op_valid, bus.instr_ready); end
            checks++; if ({bus.op_a, bus.op_b, bus.op_c} !== hold) begin errors++; $display("FAIL stall_stable cycle %0d got %0h exp %0h", i, {bus.op_a, bus.op_b, bus.op_c}, hold); end
        end
        bus.instr_valid = 1'b0;
        checks++; if (n_acc != acc0) begin errors++; $display("FAIL stall_no_accept got %0d accepts exp %0d", n_acc, acc0); end
        bus.op_ready = 1'b1;
        run_out(5, ok);
        checks++; if (!ok || {got.a, got.b, got.c} !== {exp_ops.a, exp_ops.b, exp_ops.c}) begin errors++; $display("FAIL stall_ops got %0h %0h %0h exp %0h %0h %0h", got.a, got.b, got.c, exp_ops.a, exp_ops.b, exp_ops.c); end
        checks++; if (bus.muladd_cnt !== mdl_cnt) begin errors++; $display("FAIL stall_cnt got %0h exp %0h", bus.muladd_cnt, mdl_cnt); end
    endtask

    task automatic test_flush_rdc();
        bit ok;
        bus.op_ready = 1'b1;
        send(1'b1, 5'd2, 5'd3, 5'd7, ok);
        tick();
        checks++; if (bus.rs3_sel !== 2'b10) begin errors++; $display("FAIL flush_rdc_state got sel %0h exp 2", bus.rs3_sel); end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL flush_rdc_idle got ready %0h exp 1", bus.instr_ready); end
        repeat (4) tick();
        checks++; if (lat >= 0) begin errors++; $display("FAIL flush_rdc_valid got op_valid at %0d exp never", lat); end
        checks++; if (bus.muladd_cnt !== mdl_cnt || exp_q.size() != 0) begin errors++; $display("FAIL flush_rdc_cnt got %0h exp %0h", bus.muladd_cnt, mdl_cnt); end
        send(1'b0, 5'd7, 5'd3, 5'd0, ok);
        run_out(10, ok);
        checks++; if (!ok || lat != 2 || {got.a, got.b, got.c} !== {exp_ops.a, exp_ops.b, exp_ops.c}) begin errors++; $display("FAIL flush_rdc_next got lat %0d ops %0h %0h %0h exp lat 2 ops %0h %0h %0h", lat, got.a, got.b, got.c, exp_ops.a, exp_ops.b, exp_ops.c); end
    endtask

    task automatic test_flush_out();
        bit ok;
        int acc0;
        bus.op_ready = 1'b0;
        send(1'b1, 5'd1, 5'd2, 5'd3, ok);
        for (int i = 0; i < 10 && lat < 0; i++) tick();
        bus.op_ready = 1'b1;
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %0h exp 0", bus.op_valid); end
        tick();
        checks++; if (handoff || bus.instr_ready !== 1'b1 || bus.muladd_cnt !== mdl_cnt) begin errors++; $display("FAIL flush_out_drop got ready %0h cnt %0h exp 1 %0h", bus.instr_ready, bus.muladd_cnt, mdl_cnt); end
        acc0 = n_acc;
        bus.instr_valid = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.instr_valid = 1'b0;
        checks++; if (n_acc != acc0 || bus.instr_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_accept got ready %0h accepts %0d exp 1 %0d", bus.instr_ready, n_acc, acc0); end
    endtask

    task automatic test_zero_rs3();
        bit ok;
        bus.op_ready = 1'b1;
        send(1'b1, 5'd3, 5'd5, 5'd0, ok);
        run_out(10, ok);
        checks++; if (!ok || lat != exp_lat(1'b1, 5'd0)) begin errors++; $display("FAIL zero_rs3_latency got %0d exp %0d", lat, exp_lat(1'b1, 5'd0)); end
        checks++; if (sel_cycles != exp_lat(1'b1, 5'd0) - 2) begin errors++; $display("FAIL zero_rs3_sel got %0d cycles exp %0d", sel_cycles, exp_lat(1'b1, 5'd0) - 2); end
        checks++; if (got.c !== exp_ops.c || bus.muladd_cnt !== mdl_cnt) begin errors++; $display("FAIL zero_rs3_opc got %0h cnt %0h exp %0h cnt %0h", got.c, bus.muladd_cnt, exp_ops.c, mdl_cnt); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic m;
        logic [AW-1:0] r1, r2, r3;
        for (int n = 0; n < 24; n++) begin
            m  = 1'($urandom_range(0, 1));
            r1 = AW'($urandom_range(0, 2**AW - 1));
            r2 = AW'($urandom_range(0, 2**AW - 1));
            r3 = (n % 6 == 0) ? '0 : AW'($urandom_range(0, 2**AW - 1));
            bus.op_ready = 1'($urandom_range(0, 1));
            send(m, r1, r2, r3, ok);
            ok = 1'b0;
            for (int i = 0; i < 40 && !ok; i++) begin
                bus.op_ready = 1'($urandom_range(0, 1));
                tick();
                ok = handoff;
            end
            checks++; if (!ok || {got.a, got.b, got.c} !== {exp_ops.a, exp_ops.b, exp_ops.c}) begin errors++; $display("FAIL b2b_ops #%0d got %0h %0h %0h exp %0h %0h %0h", n, got.a, got.b, got.c, exp_ops.a, exp_ops.b, exp_ops.c); end
            checks++; if (lat != exp_lat(m, r3)) begin errors++; $display("FAIL b2b_latency #%0d got %0d exp %0d", n, lat, exp_lat(m, r3)); end
        end
        checks++; if (bus.muladd_cnt !== mdl_cnt) begin errors++; $display("FAIL b2b_cnt got %0h exp %0h", bus.muladd_cnt, mdl_cnt); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bus.op_ready = 1'b0;
        send(1'b1, 5'd1, 5'd2, 5'd7, ok);
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.op_valid !== 1'b0 || bus.instr_ready !== 1'b1 || bus.muladd_cnt !== '0) begin errors++; $display("FAIL rst_mid_hs got valid %0h ready %0h cnt %0h exp 0 1 0", bus.op_valid, bus.instr_ready, bus.muladd_cnt); end
        checks++; if ({bus.rf_addr0, bus.rs3_sel, bus.op_a} !== '0) begin errors++; $display("FAIL rst_mid_regs got addr %0h sel %0h op_a %0h exp 0", bus.rf_addr0, bus.rs3_sel, bus.op_a); end
        exp_q.delete();
        pending = 1'b0;
        mdl_cnt = '0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.op_ready = 1'b1;
        send(1'b0, 5'd5, 5'd3, 5'd0, ok);
        run_out(10, ok);
        checks++; if (!ok || {got.a, got.b, got.c} !== {32'h22, 32'h11, 32'h0}) begin errors++; $display("FAIL rst_mid_next got %0h %0h %0h exp 22 11 0", got.a, got.b, got.c); end
    endtask

    task automatic test_wrap();
        bit ok;
        bus.op_ready = 1'b1;
        for (int i = 0; i < 400 && mdl_cnt != {CW{1'b1}}; i++) begin
            send(1'b1, 5'd1, 5'd2, 5'd3, ok);
            run_out(10, ok);
        end
        checks++; if (bus.muladd_cnt !== {CW{1'b1}}) begin errors++; $display("FAIL wrap_full got %0h exp %0h", bus.muladd_cnt, {CW{1'b1}}); end
        send(1'b1, 5'd1, 5'd2, 5'd3, ok);
        run_out(10, ok);
        checks++; if (bus.muladd_cnt !== '0) begin errors++; $display("FAIL wrap_zero got %0h exp 0", bus.muladd_cnt); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2**AW; i++) rf[i] = 32'h1000_0000 + 32'(i * 32'h0101);
        rf[0] = 32'h5A5A_0000;
        rf[3] = 32'h11;
        rf[5] = 32'h22;
        rf[7] = 32'hABCD;
        bus.flush       = 1'b0;
        bus.instr_valid = 1'b0;
        bus.is_muladd   = 1'b0;
        bus.rs1         = '0;
        bus.rs2         = '0;
        bus.rs3         = '0;
        bus.op_ready    = 1'b0;
        test_reset();
        test_plain();
        test_muladd();
        test_stall();
        test_flush_rdc();
        test_flush_out();
        test_zero_rs3();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
